// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared types for the alarm service blocks:
// FSM encodings, BCD mm:ss field offsets and widths.
package alarm_ring_ctrl_pkg;

  localparam int TIME_W = 16;
  localparam int RING_W = 7;

  localparam int MIN_TENS_LSB  = 12;
  localparam int MIN_UNITS_LSB = 8;
  localparam int SEC_TENS_LSB  = 4;
  localparam int SEC_UNITS_LSB = 0;

  typedef logic [TIME_W-1:0] bcd_time_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } ring_state_e;

endpackage

// File: rtl/alarm_ring_ctrl_bcd_min_add.sv
// BCD minute adder: adds 1..9 minutes to mm:ss,
// seconds kept, minutes wrap 59 -> 00.
module bcd_min_add
  import alarm_ring_ctrl_pkg::*;
(
  input  bcd_time_t  time_i,
  input  logic [3:0] incr_i,
  output bcd_time_t  time_o
);

  logic [4:0] u_sum;
  logic       carry;
  logic [3:0] u_res;
  logic [3:0] t_sum;
  logic [3:0] t_res;

  always_comb begin
    u_sum = {1'b0, time_i[MIN_UNITS_LSB +: 4]}
          + {1'b0, incr_i};
    carry = (u_sum >= 5'd10);
    u_res = carry ? (u_sum[3:0] - 4'd10) : u_sum[3:0];
    t_sum = time_i[MIN_TENS_LSB +: 4] + {3'b000, carry};
    t_res = (t_sum >= 4'd6) ? (t_sum - 4'd6) : t_sum;
    time_o = {t_res, u_res, time_i[SEC_TENS_LSB +: 4],
              time_i[SEC_UNITS_LSB +: 4]};
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: arms on an alarm load, rings on
// time match, handles dismiss / snooze and auto-stop.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int RING_SECONDS = 30,
  parameter int SNOOZE_MIN   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        arm_en,
  input  logic        alarm_load,
  input  logic [15:0] alarm_in,
  input  logic [15:0] cur_time,
  input  logic        tick_1hz,
  input  logic        push_c,
  input  logic        push_u,
  output logic        ringing,
  output logic [15:0] led,
  output logic [15:0] target,
  output logic [1:0]  state
);

  localparam logic [RING_W-1:0] RING_INIT =
    RING_W'(RING_SECONDS);
  localparam logic [RING_W-1:0] CNT_ONE = RING_W'(1);
  localparam logic [3:0] SNZ_INC = 4'(SNOOZE_MIN);

  ring_state_e       state_q, state_d;
  bcd_time_t         alarm_q, alarm_d;
  bcd_time_t         target_q, target_d;
  bcd_time_t         led_q, led_d;
  logic              ring_q, ring_d;
  logic              load_q, load_d;
  logic              loaded_q, loaded_d;
  logic [RING_W-1:0] cnt_q, cnt_d;

  bcd_time_t snz_time;
  logic      load_rise;
  logic      hit;

  bcd_min_add u_snz (
    .time_i (cur_time),
    .incr_i (SNZ_INC),
    .time_o (snz_time)
  );

  assign load_rise = alarm_load & ~load_q;
  assign hit = tick_1hz & (cur_time == target_q);

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    target_d = target_q;
    led_d    = led_q;
    ring_d   = ring_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    load_d   = alarm_load;

    if (load_rise) begin
      alarm_d  = alarm_in;
      target_d = alarm_in;
      loaded_d = 1'b1;
      ring_d   = 1'b0;
      led_d    = '0;
      cnt_d    = '0;
      state_d  = arm_en ? ST_ARMED : ST_IDLE;
    end else if (!arm_en) begin
      state_d = ST_IDLE;
      ring_d  = 1'b0;
      led_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (loaded_q) begin
            state_d  = ST_ARMED;
            target_d = alarm_q;
          end
        end
        ST_ARMED: begin
          if (hit) begin
            state_d = ST_RINGING;
            ring_d  = 1'b1;
            led_d   = '1;
            cnt_d   = RING_INIT;
          end
        end
        ST_SNOOZE: begin
          if (push_c) begin
            state_d  = ST_ARMED;
            target_d = alarm_q;
          end else if (hit) begin
            state_d = ST_RINGING;
            ring_d  = 1'b1;
            led_d   = '1;
            cnt_d   = RING_INIT;
          end
        end
        ST_RINGING: begin
          // buttons outrank a coincident tick
          if (push_c) begin
            state_d  = ST_ARMED;
            target_d = alarm_q;
            ring_d   = 1'b0;
            led_d    = '0;
            cnt_d    = '0;
          end else if (push_u) begin
            state_d  = ST_SNOOZE;
            target_d = snz_time;
            ring_d   = 1'b0;
            led_d    = '0;
            cnt_d    = '0;
          end else if (tick_1hz) begin
            cnt_d = cnt_q - CNT_ONE;
            led_d = ~led_q;
            if (cnt_q <= CNT_ONE) begin
              state_d  = ST_ARMED;
              target_d = alarm_q;
              ring_d   = 1'b0;
              led_d    = '0;
              cnt_d    = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      alarm_q  <= '0;
      target_q <= '0;
      led_q    <= '0;
      ring_q   <= 1'b0;
      load_q   <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      alarm_q  <= alarm_d;
      target_q <= target_d;
      led_q    <= led_d;
      ring_q   <= ring_d;
      load_q   <= load_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ringing = ring_q;
  assign led     = led_q;
  assign target  = target_q;
  assign state   = state_q;

endmodule
